// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared CPU constants (opcodes, PC control codes) and fetch sequencer state encoding
package fetch_ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] PC_CTRL_HOLD = 2'b00;
  localparam logic [1:0] PC_CTRL_INC  = 2'b01;
  localparam logic [1:0] PC_CTRL_LOAD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT} state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch/decode sequencer; clk/rst(async low), start, imem req/ack/rdata, pc_en/pc_ctrl/pc_offset, ir, exec valid/done, zero_flag, halted, fetch_err
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int IR_W        = 16,
  parameter int OFS_W       = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [IR_W-1:0]  imem_rdata,
  output logic             pc_en,
  output logic [1:0]       pc_ctrl,
  output logic [OFS_W-1:0] pc_offset,
  output logic [IR_W-1:0]  ir,
  output logic             exec_valid,
  input  logic             exec_done,
  input  logic             zero_flag,
  output logic             halted,
  output logic             fetch_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] ctrl_nxt;
  logic [3:0] op;
  logic tmo;
  assign op = ir[IR_W-1 -: 4];
  assign tmo = state == S_FETCH && !imem_ack && cnt == CW'(TIMEOUT_CYC - 1);
  assign imem_req = state == S_FETCH;
  assign pc_en = state == S_UPDATE;
  assign exec_valid = state == S_EXEC;
  assign halted = state == S_HALT;
  always_comb begin
    nxt = state;
    ctrl_nxt = PC_CTRL_INC;
    case (state)
      S_IDLE, S_HALT: nxt = start ? S_FETCH : state;
      S_FETCH: nxt = imem_ack ? S_DECODE : tmo ? S_HALT : S_FETCH;
      S_DECODE: begin
        nxt = op == OP_HALT ? S_HALT : (op == OP_NOP || op == OP_JMP || op == OP_JZ) ? S_UPDATE : S_EXEC;
        ctrl_nxt = (op == OP_JMP || (op == OP_JZ && zero_flag)) ? PC_CTRL_LOAD : PC_CTRL_INC;
      end
      S_EXEC: nxt = exec_done ? S_UPDATE : S_EXEC;
      S_UPDATE: nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      ir <= '0;
      pc_ctrl <= PC_CTRL_HOLD;
      pc_offset <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_FETCH) cnt <= (imem_ack || tmo) ? '0 : cnt + 1'b1;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (tmo) fetch_err <= 1'b1;
      pc_ctrl <= nxt == S_UPDATE ? ctrl_nxt : PC_CTRL_HOLD;
      if (nxt == S_UPDATE) pc_offset <= ir[OFS_W-1:0];
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl PC update sequencing, exec handshake, timeout and halt
module tb_fetch_ctrl;
  logic clk = 0, rst = 0, start = 0, imem_ack = 0, exec_done = 0, zero_flag = 0;
  logic [15:0] imem_rdata = '0;
  logic imem_req, pc_en, exec_valid, halted, fetch_err;
  logic [1:0] pc_ctrl;
  logic [7:0] pc_offset;
  logic [15:0] ir;
  int total = 0, bad = 0, pc_en_cnt = 0, exec_cnt = 0, p0, e0;
  logic [9:0] sb[$];
  fetch_ctrl dut (.clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc_en(pc_en), .pc_ctrl(pc_ctrl), .pc_offset(pc_offset), .ir(ir),
    .exec_valid(exec_valid), .exec_done(exec_done), .zero_flag(zero_flag), .halted(halted), .fetch_err(fetch_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (exec_valid) exec_cnt++;
    if (rst && pc_en) begin
      pc_en_cnt++;
      if (sb.size() == 0) chk("unexpected_pc_en", 1, 0);
      else chk("pc_update", {pc_ctrl, pc_offset}, sb.pop_front());
    end
  end
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", imem_req, 1);
  endtask
  task automatic do_fetch(input logic [15:0] w, input int waits);
    wait_req();
    repeat (waits) @(negedge clk);
    imem_ack = 1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 0;
  endtask
  task automatic run_simple(input logic [15:0] w, input logic [1:0] ctrl, input int waits);
    sb.push_back({ctrl, w[7:0]});
    do_fetch(w, waits);
    @(negedge clk);
    chk("pc_en_pulse", pc_en, 1);
    @(negedge clk);
    chk("pc_en_drop", {pc_en, pc_ctrl}, 0);
    chk("refetch_req", imem_req, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    chk("reset_outs", {imem_req, pc_en, pc_ctrl, pc_offset, ir, exec_valid, halted, fetch_err}, 0);
    rst = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("fetch_req", imem_req, 1);
    rst = 0;
    #1;
    chk("abort_outs", {imem_req, pc_en, pc_ctrl, pc_offset, ir, exec_valid, halted, fetch_err}, 0);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", imem_req, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    run_simple(16'h0000, 2'b01, 2);
    e0 = exec_cnt;
    run_simple(16'hE042, 2'b10, 0);
    chk("jmp_no_exec", exec_cnt - e0, 0);
    zero_flag = 1;
    run_simple(16'hD07F, 2'b10, 1);
    zero_flag = 0;
    run_simple(16'hD07F, 2'b01, 3);
    sb.push_back({2'b01, 8'h23});
    e0 = exec_cnt;
    do_fetch(16'h3123, 1);
    chk("decode_no_exec", exec_valid, 0);
    @(negedge clk);
    chk("exec_valid_on", exec_valid, 1);
    chk("ir_exec", ir, 16'h3123);
    repeat (5) @(negedge clk);
    exec_done = 1;
    @(negedge clk);
    exec_done = 0;
    chk("exec_cycles", exec_cnt - e0, 6);
    chk("exec_pc_en", pc_en, 1);
    @(negedge clk);
    p0 = pc_en_cnt;
    chk("timeout_req", imem_req, 1);
    repeat (14) @(negedge clk);
    chk("pre_timeout", {imem_req, halted, fetch_err}, 3'b100);
    @(negedge clk);
    chk("timeout", {imem_req, halted, fetch_err}, 3'b011);
    chk("timeout_no_pc_en", pc_en_cnt - p0, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("resume", {imem_req, halted, fetch_err}, 3'b101);
    do_fetch(16'hF000, 0);
    @(negedge clk);
    chk("halt_op", {halted, imem_req}, 2'b10);
    chk("halt_no_pc_en", pc_en_cnt - p0, 0);
    repeat (2) @(negedge clk);
    chk("halt_stays", halted, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    run_simple(16'h0005, 2'b01, 0);
    chk("pc_en_total", pc_en_cnt, 6);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
